// File: rtl/quantum_scheduler_pkg.sv
// Processor-wide control package: scheduler state encoding, datapath widths
// and the control-unit opcodes that drive the preemption timer.
package quantum_scheduler_pkg;

  localparam int QW              = 16;
  localparam int PCW             = 32;
  localparam int DEFAULT_QUANTUM = 100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PENDING = 2'd2
  } qnt_state_t;

  // Control-unit opcodes that touch the scheduler.
  localparam logic [5:0] OP_WRITEI  = 6'h2A;
  localparam logic [5:0] OP_WRITEPC = 6'h2B;
  localparam logic [5:0] OP_RSTQNT  = 6'h2C;

endpackage

// File: rtl/quantum_scheduler_qnt_down_counter.sv
// Loadable down counter for the remaining quantum; saturates at zero and
// flags the cycle on which an enabled decrement reaches zero.
module qnt_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero_next
);

  logic [W-1:0] count_reg;

  // Priority clear > load > decrement; never decrements below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign count     = count_reg;
  assign zero_next = en && (count_reg == W'(1));

endmodule

// File: rtl/quantum_scheduler.sv
// Preemption timer: counts unhalted retires of the user process and raises
// intSig when the quantum expires, latching the PC to resume from.
module quantum_scheduler
  import quantum_scheduler_pkg::*;
#(
  parameter int QW              = quantum_scheduler_pkg::QW,
  parameter int PCW             = quantum_scheduler_pkg::PCW,
  parameter int DEFAULT_QUANTUM = quantum_scheduler_pkg::DEFAULT_QUANTUM
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           retire,
  input  logic           halt,
  input  logic           rstQnt,
  input  logic           stopQnt,
  input  logic           cfgWe,
  input  logic [QW-1:0]  cfgQuantum,
  input  logic [PCW-1:0] pcNext,
  output logic           intSig,
  output logic [PCW-1:0] epc,
  output logic [QW-1:0]  qntRemain,
  output logic           armed
);

  qnt_state_t     state_reg, state_next;
  logic [PCW-1:0] epc_reg;
  logic [QW-1:0]  quantum_reg;
  logic           cnt_clr, cnt_load, cnt_en, cnt_zero_next, epc_load;
  logic           step;

  assign step = retire && !halt;

  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    epc_load   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (rstQnt) begin
          state_next = COUNT;
          cnt_load   = 1'b1;
        end
      end
      COUNT: begin
        if (stopQnt) begin
          state_next = IDLE;
          cnt_clr    = 1'b1;
        end else if (rstQnt) begin
          cnt_load = 1'b1;
        end else if (step) begin
          cnt_en = 1'b1;
          if (cnt_zero_next) begin
            state_next = PENDING;
            epc_load   = 1'b1;
          end
        end
      end
      PENDING: begin
        // Leave only once the control unit has actually taken the interrupt jump.
        if (stopQnt && step) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reload reads the pre-write quantum_reg, so a same-cycle cfgWe applies next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      epc_reg     <= '0;
      quantum_reg <= QW'(DEFAULT_QUANTUM);
    end else begin
      state_reg <= state_next;
      if (epc_load) begin
        epc_reg <= pcNext;
      end
      if (cfgWe) begin
        quantum_reg <= (cfgQuantum == '0) ? QW'(1) : cfgQuantum;
      end
    end
  end

  qnt_down_counter #(
    .W (QW)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .load      (cnt_load),
    .load_val  (quantum_reg),
    .en        (cnt_en),
    .count     (qntRemain),
    .zero_next (cnt_zero_next)
  );

  assign intSig = (state_reg == PENDING);
  assign armed  = (state_reg != IDLE);
  assign epc    = epc_reg;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed walk through the scheduler's scenarios followed by random traffic,
// all checked against a behavioural model of the quantum rules.
module tb_quantum_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        retire, halt, rstQnt, stopQnt, cfgWe;
  logic [15:0] cfgQuantum;
  logic [31:0] pcNext;
  logic        intSig;
  logic [31:0] epc;
  logic [15:0] qntRemain;
  logic        armed;

  int vectors     = 0;
  int miscompares = 0;
  int steps       = 0;

  // Reference model: mode 0 = kernel, 1 = counting, 2 = interrupt pending.
  int          m_mode;
  int          m_remain;
  int          m_quantum;
  logic [31:0] m_epc;

  always #5 clk = ~clk;

  quantum_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .retire     (retire),
    .halt       (halt),
    .rstQnt     (rstQnt),
    .stopQnt    (stopQnt),
    .cfgWe      (cfgWe),
    .cfgQuantum (cfgQuantum),
    .pcNext     (pcNext),
    .intSig     (intSig),
    .epc        (epc),
    .qntRemain  (qntRemain),
    .armed      (armed)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_remain  = 0;
    m_quantum = 100;
    m_epc     = 32'h0;
  endtask

  task automatic check_model();
    chk("intSig",    {31'b0, intSig},    {31'b0, (m_mode == 2)});
    chk("armed",     {31'b0, armed},     {31'b0, (m_mode != 0)});
    chk("qntRemain", {16'b0, qntRemain}, 32'(m_remain));
    chk("epc",       epc,                m_epc);
  endtask

  task automatic model_clock();
    int  q_old;
    bit  ticks;
    q_old = m_quantum;
    ticks = retire && !halt;
    if (cfgWe) m_quantum = (cfgQuantum == 16'd0) ? 1 : int'(cfgQuantum);
    if (m_mode == 0) begin
      if (rstQnt) begin
        m_mode   = 1;
        m_remain = q_old;
      end
    end else if (m_mode == 1) begin
      if (stopQnt) begin
        m_mode   = 0;
        m_remain = 0;
      end else if (rstQnt) begin
        m_remain = q_old;
      end else if (ticks) begin
        if (m_remain == 1) begin
          m_mode   = 2;
          m_remain = 0;
          m_epc    = pcNext;
        end else if (m_remain > 1) begin
          m_remain = m_remain - 1;
        end
      end
    end else begin
      if (stopQnt && ticks) m_mode = 0;
    end
  endtask

  task automatic step(input logic r, input logic h, input logic rq, input logic sq,
                      input logic cw, input logic [15:0] cq, input logic [31:0] pc);
    retire = r; halt = h; rstQnt = rq; stopQnt = sq;
    cfgWe = cw; cfgQuantum = cq; pcNext = pc;
    @(posedge clk);
    model_clock();
    #1;
    steps++;
    check_model();
    $display("step %0d ret=%0b halt=%0b rq=%0b sq=%0b cw=%0b cq=%0d pc=%0h -> int=%0b armed=%0b rem=%0d epc=%0h",
             steps, r, h, rq, sq, cw, cq, pc, intSig, armed, qntRemain, epc);
  endtask

  initial begin
    retire = 0; halt = 0; rstQnt = 0; stopQnt = 0; cfgWe = 0;
    cfgQuantum = '0; pcNext = '0;
    rst_n = 1'b0;
    model_reset();
    #3;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Quantum 3 with three retires.
    step(0, 0, 0, 0, 1, 16'd3, 32'h0);
    step(0, 0, 1, 0, 0, 16'd0, 32'h0);
    chk("arm_q3", {16'b0, qntRemain}, 32'd3);
    step(1, 0, 0, 0, 0, 16'd0, 32'h40);
    chk("rem_2", {16'b0, qntRemain}, 32'd2);
    step(1, 0, 0, 0, 0, 16'd0, 32'h44);
    chk("rem_1", {16'b0, qntRemain}, 32'd1);
    step(1, 0, 0, 0, 0, 16'd0, 32'h48);
    chk("expire_int", {31'b0, intSig}, 32'd1);
    chk("expire_epc", epc, 32'h48);

    // rstQnt ignored in PENDING, halted stop+retire keeps it, then acknowledge.
    step(1, 0, 1, 0, 0, 16'd0, 32'h4C);
    step(1, 1, 0, 1, 0, 16'd0, 32'h4C);
    chk("halt_keeps_pending", {31'b0, intSig}, 32'd1);
    step(1, 0, 0, 1, 0, 16'd0, 32'h4C);
    chk("ack_int_low", {31'b0, intSig}, 32'd0);
    step(1, 0, 0, 0, 0, 16'd0, 32'h50);
    chk("idle_ignores_retire", {16'b0, qntRemain}, 32'd0);

    // Halt freezes counting.
    step(0, 0, 0, 0, 1, 16'd5, 32'h0);
    step(0, 0, 1, 0, 0, 16'd0, 32'h0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 16'd0, 32'h60);
    chk("halt_frozen", {16'b0, qntRemain}, 32'd5);
    step(1, 0, 0, 0, 0, 16'd0, 32'h64);
    chk("unhalt_dec", {16'b0, qntRemain}, 32'd4);

    // Config of 0 stored as 1, applied only on reload.
    step(0, 0, 0, 0, 1, 16'd7, 32'h0);
    step(0, 0, 1, 0, 0, 16'd0, 32'h0);
    step(0, 0, 0, 0, 1, 16'd0, 32'h0);
    chk("cfg_no_effect", {16'b0, qntRemain}, 32'd7);
    step(0, 0, 1, 0, 0, 16'd0, 32'h0);
    chk("zero_as_one", {16'b0, qntRemain}, 32'd1);
    step(1, 0, 0, 0, 0, 16'd0, 32'h70);
    chk("q1_int", {31'b0, intSig}, 32'd1);
    step(1, 0, 0, 1, 0, 16'd0, 32'h74);

    // stopQnt beats rstQnt; reload mid-quantum; same-cycle cfg uses old value.
    step(0, 0, 1, 0, 0, 16'd0, 32'h0);
    step(0, 0, 1, 1, 0, 16'd0, 32'h0);
    chk("stop_wins_armed", {31'b0, armed}, 32'd0);
    step(0, 0, 0, 0, 1, 16'd4, 32'h0);
    step(0, 0, 1, 0, 0, 16'd0, 32'h0);
    step(1, 0, 0, 0, 0, 16'd0, 32'h80);
    step(1, 0, 0, 0, 0, 16'd0, 32'h84);
    chk("at_two", {16'b0, qntRemain}, 32'd2);
    step(0, 0, 1, 0, 0, 16'd0, 32'h0);
    chk("reload_4", {16'b0, qntRemain}, 32'd4);
    step(0, 0, 1, 0, 1, 16'd9, 32'h0);
    chk("reload_old_q", {16'b0, qntRemain}, 32'd4);
    step(0, 0, 1, 0, 0, 16'd0, 32'h0);
    chk("reload_new_q", {16'b0, qntRemain}, 32'd9);

    // Async reset while PENDING.
    step(0, 0, 0, 1, 1, 16'd1, 32'h0);
    step(0, 0, 1, 0, 0, 16'd0, 32'h0);
    step(1, 0, 0, 0, 0, 16'd0, 32'h48);
    chk("pending_epc", epc, 32'h48);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1, 0, 0, 16'd0, 32'h0);
    chk("default_q", {16'b0, qntRemain}, 32'd100);
    step(0, 0, 0, 1, 0, 16'd0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic r, h, rq, sq, cw;
      logic [15:0] cq;
      r  = ($urandom_range(99) < 70);
      h  = ($urandom_range(99) < 15);
      rq = ($urandom_range(99) < 6);
      sq = ($urandom_range(99) < 10);
      cw = ($urandom_range(99) < 8);
      cq = 16'($urandom_range(6));
      step(r, h, rq, sq, cw, cq, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
